fetch_stage: RTL and testbench

- IF stage of the pipelined LEGv8 core: holds the PC, drives the combinational instruction-ROM address, and registers the returned word into the IF/ID pipeline register.
- Consumes branch redirects from downstream, stall from the hazard unit, and flush for wrong-path squash.
- Sits directly upstream of decode; its only memory client is the 128-entry, 32-bit instruction ROM.

---
 rtl/core_pkg.sv | 9 +
 rtl/fetch_pipe_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 76 +++++++
 tb/tb_fetch_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and types for the LEGv8 pipeline front end.
// NOP_INSTR is ADD XZR,XZR,XZR, the canonical pipeline bubble.
package core_pkg;
  localparam int          IW        = 32;
  localparam logic [31:0] NOP_INSTR = 32'h8b1f03ff;
  localparam logic [63:0] PC_RESET  = 64'd0;

  typedef enum logic {BOOT, RUN} fetch_state_t;
endpackage

// File: rtl/fetch_pipe_reg.sv
// IF/ID pipeline register: async active-low reset, enable (not stalled)
// and a synchronous clear that injects a bubble; clear beats enable.
module fetch_pipe_reg #(
  parameter int N  = 64,
  parameter int IW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [IW-1:0] instr_i,
  input  logic [N-1:0]  pc_i,
  input  logic          valid_i,
  output logic [IW-1:0] instr_o,
  output logic [N-1:0]  pc_o,
  output logic          valid_o
);
  import core_pkg::*;

  logic [IW-1:0] instr_q;
  logic [N-1:0]  pc_q;
  logic          valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q <= IW'(NOP_INSTR);
      pc_q    <= N'(PC_RESET);
      valid_q <= 1'b0;
    end else if (clr_i) begin
      instr_q <= IW'(NOP_INSTR);
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (en_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= valid_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// LEGv8 IF stage: PC register, instruction-ROM addressing and the IF/ID
// register, with branch redirect, stall, flush and out-of-ROM detection.
module fetch_stage #(
  parameter int N  = 64,
  parameter int IW = core_pkg::IW,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_F,
  input  logic          flush_D,
  input  logic          pcsrc,
  input  logic [N-1:0]  branch_target,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_q,
  output logic [N-1:0]  pc_F,
  output logic [IW-1:0] instr_D,
  output logic [N-1:0]  pc_D,
  output logic          valid_D,
  output logic          oob_F,
  output logic [31:0]   fetch_count
);
  import core_pkg::*;

  fetch_state_t  state_q;
  logic [N-1:0]  pc_q, pc_d;
  logic [31:0]   count_q, count_d;
  logic          ifIdClr, ifIdEn, accept;
  logic [IW-1:0] fetchInstr;
  logic          fetchValid;

  // A redirect outranks a stall so a wrong-path PC is never held.
  always_comb begin
    pc_d = pc_q + N'(4);
    if (pcsrc)        pc_d = branch_target & ~N'(3);
    else if (stall_F) pc_d = pc_q;
  end

  assign oob_F      = |pc_q[N-1:AW+2];
  assign imem_addr  = (state_q == BOOT) ? '0 : pc_q[AW+1:2];
  assign fetchInstr = oob_F ? IW'(NOP_INSTR) : imem_q;
  assign fetchValid = ~oob_F;

  assign ifIdClr = flush_D | pcsrc;
  assign ifIdEn  = ~stall_F;
  assign accept  = ~ifIdClr & ifIdEn & ~oob_F;
  assign count_d = (accept && count_q != 32'hFFFF_FFFF) ? count_q + 32'd1 : count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= N'(PC_RESET);
      count_q <= '0;
    end else begin
      state_q <= RUN;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  fetch_pipe_reg #(.N(N), .IW(IW)) u_ifid (
    .clk_i   (clk),
    .rst_ni  (reset),
    .en_i    (ifIdEn),
    .clr_i   (ifIdClr),
    .instr_i (fetchInstr),
    .pc_i    (pc_q),
    .valid_i (fetchValid),
    .instr_o (instr_D),
    .pc_o    (pc_D),
    .valid_o (valid_D)
  );

  assign pc_F        = pc_q;
  assign fetch_count = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed steps push hand-computed
// post-edge expectations; a negedge monitor pops and compares them.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h8b1f03ff;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_F, flush_D, pcsrc;
  logic [63:0] branch_target;
  logic [6:0]  imem_addr;
  logic [31:0] imem_q;
  logic [63:0] pc_F, pc_D;
  logic [31:0] instr_D, fetch_count;
  logic        valid_D, oob_F;

  logic [31:0] rom [128];

  typedef struct {
    string       name;
    logic [63:0] pcF;
    logic [31:0] instrD;
    logic [63:0] pcD;
    logic        validD;
    logic [31:0] count;
    logic        oob;
    logic [6:0]  addr;
    bit          pcdCare;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_F       (stall_F),
    .flush_D       (flush_D),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_q        (imem_q),
    .pc_F          (pc_F),
    .instr_D       (instr_D),
    .pc_D          (pc_D),
    .valid_D       (valid_D),
    .oob_F         (oob_F),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_q = rom[imem_addr];

  task automatic checkField(input string nm, input string fld, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s.%s: got %0h expected %0h", nm, fld, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField(e.name, "pc_F",        pc_F,        e.pcF);
    checkField(e.name, "instr_D",     64'(instr_D), 64'(e.instrD));
    if (e.pcdCare) checkField(e.name, "pc_D", pc_D, e.pcD);
    checkField(e.name, "valid_D",     64'(valid_D), 64'(e.validD));
    checkField(e.name, "fetch_count", 64'(fetch_count), 64'(e.count));
    checkField(e.name, "oob_F",       64'(oob_F),   64'(e.oob));
    checkField(e.name, "imem_addr",   64'(imem_addr), 64'(e.addr));
  endtask

  function automatic exp_t mk(input string nm, input logic [63:0] ePcF, input logic [31:0] eInstr,
                              input logic [63:0] ePcD, input logic eV, input int eCnt,
                              input logic eOob, input logic [6:0] eAddr, input bit care);
    exp_t e;
    e.name = nm; e.pcF = ePcF; e.instrD = eInstr; e.pcD = ePcD; e.validD = eV;
    e.count = 32'(eCnt); e.oob = eOob; e.addr = eAddr; e.pcdCare = care;
    return e;
  endfunction

  // Called at negedge+1; the expectation describes state after the next rising edge.
  task automatic applyStimulus(input logic st, input logic fl, input logic br, input logic [63:0] tgt,
                               input exp_t e);
    stall_F = st; flush_D = fl; pcsrc = br; branch_target = tgt;
    expQ.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t rstExp;
    for (int i = 0; i < 128; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[0] = 32'hf8000001;
    rom[1] = 32'hf8008002;
    rstExp = mk("reset", 64'h0, NOP, 64'h0, 1'b0, 0, 1'b0, 7'd0, 1'b1);

    reset = 1'b0; stall_F = 1'b0; flush_D = 1'b0; pcsrc = 1'b0; branch_target = '0;
    #1;
    expQ.push_back(rstExp);
    @(negedge clk);
    #1;
    reset = 1'b1;

    applyStimulus(0,0,0,64'h0,  mk("boot",   64'h04, 32'hf8000001, 64'h00, 1, 1, 0, 7'd1, 1));
    applyStimulus(0,0,0,64'h0,  mk("run1",   64'h08, 32'hf8008002, 64'h04, 1, 2, 0, 7'd2, 1));
    applyStimulus(0,0,0,64'h0,  mk("run2",   64'h0C, 32'hA0000002, 64'h08, 1, 3, 0, 7'd3, 1));
    applyStimulus(0,0,0,64'h0,  mk("run3",   64'h10, 32'hA0000003, 64'h0C, 1, 4, 0, 7'd4, 1));
    applyStimulus(1,0,0,64'h0,  mk("stall1", 64'h10, 32'hA0000003, 64'h0C, 1, 4, 0, 7'd4, 1));
    applyStimulus(1,0,0,64'h0,  mk("stall2", 64'h10, 32'hA0000003, 64'h0C, 1, 4, 0, 7'd4, 1));
    applyStimulus(0,0,0,64'h0,  mk("unstall",64'h14, 32'hA0000004, 64'h10, 1, 5, 0, 7'd5, 1));
    applyStimulus(0,0,0,64'h0,  mk("run4",   64'h18, 32'hA0000005, 64'h14, 1, 6, 0, 7'd6, 1));
    applyStimulus(0,0,0,64'h0,  mk("run5",   64'h1C, 32'hA0000006, 64'h18, 1, 7, 0, 7'd7, 1));
    applyStimulus(0,0,0,64'h0,  mk("run6",   64'h20, 32'hA0000007, 64'h1C, 1, 8, 0, 7'd8, 1));
    applyStimulus(0,0,1,64'h57, mk("branch", 64'h54, NOP,          64'h00, 0, 8, 0, 7'd21, 1));
    applyStimulus(0,0,0,64'h0,  mk("target", 64'h58, 32'hA0000015, 64'h54, 1, 9, 0, 7'd22, 1));
    applyStimulus(1,0,1,64'h8,  mk("brStall",64'h08, NOP,          64'h00, 0, 9, 0, 7'd2, 1));
    applyStimulus(0,0,0,64'h0,  mk("brTgt2", 64'h0C, 32'hA0000002, 64'h08, 1, 10, 0, 7'd3, 1));
    applyStimulus(1,1,0,64'h0,  mk("stFlush",64'h0C, NOP,          64'h00, 0, 10, 0, 7'd3, 1));
    applyStimulus(0,0,0,64'h0,  mk("resume", 64'h10, 32'hA0000003, 64'h0C, 1, 11, 0, 7'd4, 1));
    applyStimulus(0,0,1,64'h1FC,mk("toEnd",  64'h1FC, NOP,         64'h00, 0, 11, 0, 7'd127, 1));
    applyStimulus(0,0,0,64'h0,  mk("last",   64'h200, 32'hA000007F,64'h1FC,1, 12, 1, 7'd0, 1));
    applyStimulus(0,0,0,64'h0,  mk("oob",    64'h204, NOP,         64'h200,0, 12, 1, 7'd1, 0));
    applyStimulus(0,0,1,64'h40, mk("back",   64'h40, NOP,          64'h00, 0, 12, 0, 7'd16, 1));
    applyStimulus(0,1,0,64'h0,  mk("flush",  64'h44, NOP,          64'h00, 0, 12, 0, 7'd17, 1));
    applyStimulus(0,0,0,64'h0,  mk("postFl", 64'h48, 32'hA0000011, 64'h44, 1, 13, 0, 7'd18, 1));

    // Reset dropped between edges must take effect without a clock.
    reset = 1'b0;
    #1;
    rstExp.name = "asyncRst";
    checkOutput(rstExp);
    rstExp.name = "rstHeld";
    expQ.push_back(rstExp);
    @(negedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(0,0,0,64'h0,  mk("reboot", 64'h04, 32'hf8000001, 64'h00, 1, 1, 0, 7'd1, 1));

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
